spi_byte_engine: RTL and testbench

- Hardware SPI master replacing per-bit CPU toggling of SCLK/MOSI for SD card access.
- Sits directly downstream of the I/O address decoder. The decoder hands it single-cycle register-access strobes already synchronised to MHZ48.
- Drives MOSI/SCLK and the SD chip selects.
- One data byte per CPU write; the received byte is readable after completion.

---
 rtl/kolibri_spi_pkg.sv | 24 ++
 rtl/spi_half_timer.sv | 42 ++++
 rtl/spi_byte_engine.sv | 168 ++++++++++++++++
 tb/tb_spi_byte_engine.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kolibri_spi_pkg.sv
// Shared constants, register layout and FSM encoding for the SPI byte engine.
// No configuration macro is read here.
package kolibri_spi_pkg;

   localparam logic RS_DATA = 1'b0;
   localparam logic RS_CTRL = 1'b1;

   localparam int B_NSD0 = 0;
   localparam int B_NSD1 = 1;
   localparam int B_SLOW = 2;
   localparam int B_OVR  = 6;
   localparam int B_BUSY = 7;

   localparam int DIV_FAST_DEF = 12;
   localparam int DIV_SLOW_DEF = 60;
   localparam int CW_DEF       = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LO,
      ST_HI
   } spi_state_e;

endpackage

// File: rtl/spi_half_timer.sv
// SCLK half-period counter; the divider choice is latched at each period start
// so a SLOW change mid-transfer only affects the next half-period.
module spi_half_timer
   import kolibri_spi_pkg::*;
#(
   parameter int DIV_FAST = DIV_FAST_DEF,
   parameter int DIV_SLOW = DIV_SLOW_DEF,
   parameter int CW       = CW_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic slow,
   output logic tick
);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] half_m1;
   logic          slow_q, slow_d;

   always_comb begin
      half_m1 = slow_q ? CW'(DIV_SLOW - 1) : CW'(DIV_FAST - 1);
      tick    = !clear && (cnt_q == half_m1);
      cnt_d   = cnt_q + 1'b1;
      slow_d  = slow_q;
      if (clear || tick) begin
         cnt_d  = '0;
         slow_d = slow;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         slow_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         slow_q <= slow_d;
      end
   end

endmodule

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte master for SD card access, one byte per DATA access.
// Define SPI_AUTOREAD_EN to let DATA reads in IDLE launch an 8'hFF transfer.
module spi_byte_engine
   import kolibri_spi_pkg::*;
#(
   parameter int DIV_FAST = DIV_FAST_DEF,
   parameter int DIV_SLOW = DIV_SLOW_DEF,
   parameter int CW       = CW_DEF
) (
   input  logic       MHZ48,
   input  logic       nRES,
   input  logic       ACC,
   input  logic       RW,
   input  logic       RS,
   input  logic [7:0] DIN,
   output logic [7:0] DOUT,
   output logic       BUSY,
   output logic       SCLK,
   output logic       MOSI,
   input  logic       MISO,
   output logic       nSD0,
   output logic       nSD1
);

   spi_state_e state_q, state_d;
   logic [7:0] shreg_q, shreg_d;
   logic [7:0] rx_q, rx_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic       miso_q, miso_d;
   logic       sclk_q, sclk_d;
   logic       mosi_q, mosi_d;
   logic       busy_q, busy_d;
   logic       nsd0_q, nsd0_d;
   logic       nsd1_q, nsd1_d;
   logic       slow_q, slow_d;
   logic       ovr_q, ovr_d;

   logic       data_wr, ctrl_wr, launch_rd, req;
   logic       tick;
   logic [7:0] ctrl;

   assign data_wr = ACC && !RW && (RS == RS_DATA);
   assign ctrl_wr = ACC && !RW && (RS == RS_CTRL);
`ifdef SPI_AUTOREAD_EN
   assign launch_rd = ACC && RW && (RS == RS_DATA);
`else
   assign launch_rd = 1'b0;
`endif
   assign req = data_wr || launch_rd;

   spi_half_timer #(
      .DIV_FAST(DIV_FAST),
      .DIV_SLOW(DIV_SLOW),
      .CW      (CW)
   ) u_timer (
      .clk  (MHZ48),
      .rst_n(nRES),
      .clear(state_q == ST_IDLE),
      .slow (slow_q),
      .tick (tick)
   );

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      rx_d     = rx_q;
      bitcnt_d = bitcnt_q;
      miso_d   = miso_q;
      sclk_d   = sclk_q;
      mosi_d   = mosi_q;
      busy_d   = busy_q;
      nsd0_d   = nsd0_q;
      nsd1_d   = nsd1_q;
      slow_d   = slow_q;
      ovr_d    = ovr_q;

      if (ctrl_wr) begin
         nsd0_d = DIN[B_NSD0];
         nsd1_d = DIN[B_NSD1];
         slow_d = DIN[B_SLOW];
         ovr_d  = 1'b0;
      end
      if (req && state_q != ST_IDLE) ovr_d = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               shreg_d  = data_wr ? DIN : 8'hFF;
               mosi_d   = data_wr ? DIN[7] : 1'b1;
               bitcnt_d = 3'd0;
               busy_d   = 1'b1;
               state_d  = ST_LO;
            end
         end
         ST_LO: begin
            if (tick) begin
               sclk_d  = 1'b1;
               miso_d  = MISO;
               state_d = ST_HI;
            end
         end
         ST_HI: begin
            if (tick) begin
               sclk_d = 1'b0;
               if (bitcnt_q == 3'd7) begin
                  rx_d    = {shreg_q[6:0], miso_q};
                  busy_d  = 1'b0;
                  mosi_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  shreg_d  = {shreg_q[6:0], miso_q};
                  mosi_d   = shreg_q[6];
                  bitcnt_d = bitcnt_q + 3'd1;
                  state_d  = ST_LO;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge MHZ48 or negedge nRES) begin
      if (!nRES) begin
         state_q  <= ST_IDLE;
         shreg_q  <= 8'h00;
         rx_q     <= 8'hFF;
         bitcnt_q <= 3'd0;
         miso_q   <= 1'b0;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b1;
         busy_q   <= 1'b0;
         nsd0_q   <= 1'b1;
         nsd1_q   <= 1'b1;
         slow_q   <= 1'b1;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         rx_q     <= rx_d;
         bitcnt_q <= bitcnt_d;
         miso_q   <= miso_d;
         sclk_q   <= sclk_d;
         mosi_q   <= mosi_d;
         busy_q   <= busy_d;
         nsd0_q   <= nsd0_d;
         nsd1_q   <= nsd1_d;
         slow_q   <= slow_d;
         ovr_q    <= ovr_d;
      end
   end

   always_comb begin
      ctrl         = 8'h00;
      ctrl[B_BUSY] = busy_q;
      ctrl[B_OVR]  = ovr_q;
      ctrl[B_SLOW] = slow_q;
      ctrl[B_NSD1] = nsd1_q;
      ctrl[B_NSD0] = nsd0_q;
   end

   assign DOUT = (RS == RS_CTRL) ? ctrl : rx_q;
   assign BUSY = busy_q;
   assign SCLK = sclk_q;
   assign MOSI = mosi_q;
   assign nSD0 = nsd0_q;
   assign nSD1 = nsd1_q;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed bench for spi_byte_engine: timing, data path, overrun, reset abort.
// Covers the SPI_AUTOREAD_EN build when that macro is defined.
module tb_spi_byte_engine;

   logic       MHZ48 = 1'b0;
   logic       nRES;
   logic       ACC;
   logic       RW;
   logic       RS;
   logic [7:0] DIN;
   logic [7:0] DOUT;
   logic       BUSY;
   logic       SCLK;
   logic       MOSI;
   logic       MISO;
   logic       nSD0;
   logic       nSD1;

   logic       miso_loop;
   logic       miso_drv;

   int checks = 0;
   int errors = 0;

   assign MISO = miso_loop ? MOSI : miso_drv;

   always #10 MHZ48 = ~MHZ48;

   spi_byte_engine dut (
      .MHZ48(MHZ48),
      .nRES (nRES),
      .ACC  (ACC),
      .RW   (RW),
      .RS   (RS),
      .DIN  (DIN),
      .DOUT (DOUT),
      .BUSY (BUSY),
      .SCLK (SCLK),
      .MOSI (MOSI),
      .MISO (MISO),
      .nSD0 (nSD0),
      .nSD1 (nSD1)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; the access lands on the following posedge.
   task automatic bus_write(input logic rs, input logic [7:0] d);
      ACC = 1'b1;
      RW  = 1'b0;
      RS  = rs;
      DIN = d;
      @(negedge MHZ48);
      ACC = 1'b0;
      RS  = 1'b0;
   endtask

   task automatic bus_read(input logic rs, output logic [7:0] v);
      ACC = 1'b1;
      RW  = 1'b1;
      RS  = rs;
      #1 v = DOUT;
      @(negedge MHZ48);
      ACC = 1'b0;
      RW  = 1'b0;
      RS  = 1'b0;
   endtask

   task automatic peek(input logic rs, output logic [7:0] v);
      RS = rs;
      #1 v = DOUT;
      RS = 1'b0;
   endtask

   task automatic run_xfer(output int fall_n, output int rises,
                           output int first_rise, output int high_cnt,
                           output logic [7:0] mosi_bits,
                           output logic sel_hi, output logic [7:0] ctrl_mid);
      logic prev;
      prev       = SCLK;
      fall_n     = 0;
      rises      = 0;
      first_rise = 0;
      high_cnt   = 0;
      mosi_bits  = 8'h00;
      sel_hi     = 1'b0;
      ctrl_mid   = 8'h00;
      for (int n = 1; n <= 3000; n++) begin
         @(negedge MHZ48);
         if (SCLK && !prev) begin
            rises++;
            if (first_rise == 0) first_rise = n;
            mosi_bits = {mosi_bits[6:0], MOSI};
         end
         if (SCLK) high_cnt++;
         if (nSD0) sel_hi = 1'b1;
         prev = SCLK;
         if (n == 100) peek(1'b1, ctrl_mid);
         if (!BUSY) begin
            fall_n = n;
            break;
         end
      end
   endtask

   task automatic wait_idle(output int n_out);
      n_out = 0;
      for (int n = 1; n <= 3000; n++) begin
         @(negedge MHZ48);
         if (!BUSY) begin
            n_out = n;
            break;
         end
      end
   endtask

   initial begin
      int         fall_n, rises, first_rise, high_cnt, n_idle;
      logic [7:0] bits, v, ctrl_mid;
      logic       sel_hi;

      nRES      = 1'b0;
      ACC       = 1'b0;
      RW        = 1'b0;
      RS        = 1'b0;
      DIN       = 8'h00;
      miso_loop = 1'b0;
      miso_drv  = 1'b1;
      repeat (3) @(negedge MHZ48);
      nRES = 1'b1;
      @(negedge MHZ48);

      peek(1'b1, v);
      chk("reset_ctrl", v, 8'h07);
      chk("reset_sclk", SCLK, 1'b0);
      chk("reset_mosi", MOSI, 1'b1);
      chk("reset_busy", BUSY, 1'b0);
      peek(1'b0, v);
      chk("reset_rx", v, 8'hFF);

      // Slow mode, loopback
      @(negedge MHZ48);
      miso_loop = 1'b1;
      bus_write(1'b1, 8'h06);
      peek(1'b1, v);
      chk("slow_ctrl", v, 8'h06);
      @(negedge MHZ48);
      bus_write(1'b0, 8'hA5);
      run_xfer(fall_n, rises, first_rise, high_cnt, bits, sel_hi, ctrl_mid);
      chk("slow_fall", fall_n, 960);
      chk("slow_rises", rises, 8);
      chk("slow_first_rise", first_rise, 60);
      chk("slow_high_cycles", high_cnt, 480);
      chk("slow_mosi_bits", bits, 8'hA5);
      chk("slow_sel_held", sel_hi, 1'b0);
      chk("slow_ctrl_mid", ctrl_mid, 8'h86);
      chk("slow_sclk_idle", SCLK, 1'b0);
      chk("slow_mosi_idle", MOSI, 1'b1);
      peek(1'b0, v);
      chk("slow_rx", v, 8'hA5);

      // Fast mode, MISO tied low
      @(negedge MHZ48);
      miso_loop = 1'b0;
      miso_drv  = 1'b0;
      bus_write(1'b1, 8'h02);
      bus_write(1'b0, 8'h3C);
      run_xfer(fall_n, rises, first_rise, high_cnt, bits, sel_hi, ctrl_mid);
      chk("fast_fall", fall_n, 192);
      chk("fast_rises", rises, 8);
      chk("fast_first_rise", first_rise, 12);
      chk("fast_high_cycles", high_cnt, 96);
      chk("fast_mosi_bits", bits, 8'h3C);
      chk("fast_sel_held", sel_hi, 1'b0);
      chk("fast_ctrl_mid", ctrl_mid, 8'h82);
      peek(1'b0, v);
      chk("fast_rx", v, 8'h00);

      // Overrun at cycle 50
      @(negedge MHZ48);
      miso_loop = 1'b1;
      bus_write(1'b0, 8'h11);
      repeat (49) @(negedge MHZ48);
      bus_write(1'b0, 8'h22);
      peek(1'b1, v);
      chk("ovr_ctrl_busy", v, 8'hC2);
      wait_idle(n_idle);
      chk("ovr_fall", n_idle, 142);
      peek(1'b0, v);
      chk("ovr_rx", v, 8'h11);
      peek(1'b1, v);
      chk("ovr_sticky", v, 8'h42);
      @(negedge MHZ48);
      bus_write(1'b1, 8'h02);
      peek(1'b1, v);
      chk("ovr_cleared", v, 8'h02);

      // Write on the very edge BUSY falls
      @(negedge MHZ48);
      bus_write(1'b0, 8'h5A);
      repeat (191) @(negedge MHZ48);
      bus_write(1'b0, 8'h33);
      chk("edge_busy_fell", BUSY, 1'b0);
      peek(1'b1, v);
      chk("edge_ovr", v, 8'h42);
      repeat (5) @(negedge MHZ48);
      chk("edge_no_start", BUSY, 1'b0);
      peek(1'b0, v);
      chk("edge_rx", v, 8'h5A);
      @(negedge MHZ48);
      bus_write(1'b1, 8'h02);

      // Reset mid-transfer
      bus_write(1'b0, 8'hC3);
      repeat (99) @(negedge MHZ48);
      chk("abort_busy_before", BUSY, 1'b1);
      nRES = 1'b0;
      #1;
      chk("abort_sclk", SCLK, 1'b0);
      chk("abort_mosi", MOSI, 1'b1);
      chk("abort_nsd0", nSD0, 1'b1);
      chk("abort_busy", BUSY, 1'b0);
      peek(1'b1, v);
      chk("abort_ctrl", v, 8'h07);
      @(negedge MHZ48);
      nRES = 1'b1;
      @(negedge MHZ48);
      peek(1'b0, v);
      chk("abort_rx", v, 8'hFF);

      @(negedge MHZ48);
      miso_loop = 1'b0;
      miso_drv  = 1'b0;
      bus_write(1'b1, 8'h02);
`ifdef SPI_AUTOREAD_EN
      bus_read(1'b0, v);
      chk("auto_first_read", v, 8'hFF);
      run_xfer(fall_n, rises, first_rise, high_cnt, bits, sel_hi, ctrl_mid);
      chk("auto_fall", fall_n, 192);
      chk("auto_rises", rises, 8);
      chk("auto_mosi_bits", bits, 8'hFF);
      @(negedge MHZ48);
      bus_read(1'b0, v);
      chk("auto_rx", v, 8'h00);
      bus_read(1'b0, v);
      chk("auto_busy_read", v, 8'h00);
      peek(1'b1, v);
      chk("auto_ovr", v, 8'hC2);
      wait_idle(n_idle);
      chk("auto_second_fall", n_idle, 191);
`else
      bus_read(1'b0, v);
      chk("plain_read", v, 8'hFF);
      repeat (5) @(negedge MHZ48);
      chk("plain_no_start", BUSY, 1'b0);
      peek(1'b1, v);
      chk("plain_no_ovr", v, 8'h02);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
